uart_cmd_ctrl: RTL
==================

Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART receiver, a register file and the UART transmitter. It parses byte frames from the receiver (P_DATA/data_valid) into register write and read commands, and drives the register file. Read results are returned to the transmitter through a valid/busy handshake. An inactivity timeout aborts partial frames.

Parameters:
DATA_WIDTH, 8, byte width of RX/TX/register data
ADDR_WIDTH, 4, register file address width; address byte truncated to low ADDR_WIDTH bits
CMD_WR, 8'hAA, write opcode; frame = opcode, addr, data
CMD_RD, 8'hBB, read opcode; frame = opcode, addr
TIMEOUT_CYCLES, 1024, max clk cycles between frame bytes, or read latency, before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  receiver data_valid; level or pulse, rising edge marks a new byte
TX_BUSY  in  1  transmitter busy
TX_P_DATA  out  DATA_WIDTH  byte to transmit
TX_D_VLD  out  1  transmit request
RF_ADDR  out  ADDR_WIDTH  register address
RF_WR_EN  out  1  one-cycle write strobe
RF_WR_DATA  out  DATA_WIDTH  write data
RF_RD_EN  out  1  one-cycle read strobe
RF_RD_DATA  in  DATA_WIDTH  read data
RF_RD_VLD  in  1  read data valid
CMD_ERR  out  1  one-cycle pulse on frame abort or unknown opcode

Behaviour:
- Reset (rst=0, any time, asynchronous): state IDLE, timeout counter 0, RX edge register 0. All outputs 0.
- Byte acceptance: RX_D_VLD registered each cycle. A byte is accepted on the edge where RX_D_VLD=1 and the registered value was 0. RX_P_DATA is captured on that edge. A held-high RX_D_VLD yields exactly one byte.
- All outputs are registered.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_REQ.
- IDLE:
  - Accepted byte == CMD_WR -> WR_ADDR.
  - Accepted byte == CMD_RD -> RD_ADDR.
  - Any other byte: stay in IDLE and pulse CMD_ERR.
- WR_ADDR: accepted byte -> latch address, go to WR_DATA.
- WR_DATA: accepted byte -> next cycle RF_WR_EN=1 for exactly one cycle, with RF_ADDR and RF_WR_DATA valid. Then IDLE.
- RD_ADDR: accepted byte -> next cycle RF_RD_EN=1 for one cycle with RF_ADDR valid. Then RD_WAIT.
- RD_WAIT: RF_RD_VLD=1 -> latch RF_RD_DATA into TX_P_DATA, go to TX_REQ. RF_RD_VLD in the same cycle as RF_RD_EN is legal and accepted.
- TX_REQ: TX_D_VLD=1 with TX_P_DATA stable until TX_BUSY is sampled 1. Next cycle TX_D_VLD=0, go to IDLE. If TX_BUSY is already 1 on entry, TX_D_VLD is held until TX_BUSY has been sampled 0 and then 1.
- RF_ADDR and RF_WR_DATA hold their last values between strobes.
- Bytes accepted in RD_WAIT or TX_REQ are dropped and do not affect state.
- Timeout:
  - Counter clears on entry to WR_ADDR, WR_DATA, RD_ADDR or RD_WAIT, and on every accepted byte.
  - Counter increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, CMD_ERR pulses one cycle, no strobe issued.
  - No timeout in IDLE or TX_REQ.
- Simultaneous: an accepted byte and the timeout in the same cycle -> the byte wins and the counter clears.
- Back-to-back frames: a new opcode accepted in the cycle after return to IDLE is processed normally.

Optional Feature:
Macro UART_CMD_ERR_RESP_EN.
- Defined: every CMD_ERR event (unknown opcode or timeout abort) also queues error byte 8'hEE. The FSM enters TX_REQ with TX_P_DATA=8'hEE and follows the normal TX handshake before IDLE.
- Undefined: errors only pulse CMD_ERR and the FSM returns straight to IDLE. No TX traffic is generated on errors.

Test Plan:
- Reset mid-frame: after bytes AA,03, pull rst low -> all outputs 0 immediately; state IDLE; next frame AA,05,3C writes 3C to address 5.
- Write frame AA,07,5A -> exactly one RF_WR_EN pulse, RF_ADDR=7, RF_WR_DATA=5A, one cycle after the 5A edge; TX_D_VLD stays 0.
- Read frame BB,07 with the register file returning 5A two cycles after RF_RD_EN -> one RF_RD_EN pulse with RF_ADDR=7; TX_P_DATA=5A and TX_D_VLD=1 until TX_BUSY=1, then TX_D_VLD=0.
- Unknown opcode 8'h12 then frame AA,01,FF -> CMD_ERR pulses once; write to address 1 with data FF completes normally.
  - With UART_CMD_ERR_RESP_EN defined, TX emits EE first.
- Timeout: send AA, then idle for TIMEOUT_CYCLES -> CMD_ERR pulse, no RF_WR_EN; next byte 8'h07 is treated as an opcode and flagged as an error.
- RX_D_VLD held high for 20 cycles with byte BB, then a new edge with byte 02 -> exactly one read, RF_RD_EN with RF_ADDR=2.
  - A byte arriving during TX_REQ is dropped.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses UART RX byte frames into register-file write/read
// commands and returns read data to the UART transmitter.
//   write frame: CMD_WR, addr, data      read frame: CMD_RD, addr
// Optional feature macro: UART_CMD_ERR_RESP_EN (every CMD_ERR also sends 8'hEE on TX).
module uart_cmd_ctrl #(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           ADDR_WIDTH     = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_WR         = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] CMD_RD         = 8'hBB,
  parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic                  RF_WR_EN,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  output logic                  RF_RD_EN,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
  input  logic                  RF_RD_VLD,
  output logic                  CMD_ERR
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef UART_CMD_ERR_RESP_EN
  localparam logic [DATA_WIDTH-1:0] ERR_BYTE = DATA_WIDTH'(8'hEE);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_TX_REQ
  } state_t;

  state_t                  state_q,      state_d;
  logic                    rx_vld_q,     rx_vld_d;
  logic [CNT_W-1:0]        cnt_q,        cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
  logic                    seen_low_q,   seen_low_d;
  logic [DATA_WIDTH-1:0]   tx_data_q,    tx_data_d;
  logic                    tx_vld_q,     tx_vld_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_q,    rf_addr_d;
  logic                    rf_wr_en_q,   rf_wr_en_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                    rf_rd_en_q,   rf_rd_en_d;
  logic                    cmd_err_q,    cmd_err_d;

  logic byte_acc;
  logic timed;
  logic timeout;
  logic abort;

  // Next-state, timeout counter and registered-output computation
  always_comb begin
    state_d      = state_q;
    rx_vld_d     = RX_D_VLD;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    seen_low_d   = seen_low_q;
    tx_data_d    = tx_data_q;
    tx_vld_d     = tx_vld_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    cmd_err_d    = 1'b0;
    abort        = 1'b0;
    timeout      = 1'b0;

    byte_acc = RX_D_VLD & ~rx_vld_q;
    timed    = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA) ||
               (state_q == S_RD_ADDR) || (state_q == S_RD_WAIT);

    // Counter rests at zero outside the timed states, so entry to a timed
    // state always starts from zero; an accepted byte beats a timeout.
    if (!timed || byte_acc) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      timeout = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (byte_acc) begin
          if (RX_P_DATA == CMD_WR) begin
            state_d = S_WR_ADDR;
          end else if (RX_P_DATA == CMD_RD) begin
            state_d = S_RD_ADDR;
          end else begin
            abort = 1'b1;
          end
        end
      end
      S_WR_ADDR: begin
        if (byte_acc) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = S_WR_DATA;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      S_WR_DATA: begin
        if (byte_acc) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = addr_q;
          rf_wr_data_d = RX_P_DATA;
          state_d      = S_IDLE;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      S_RD_ADDR: begin
        if (byte_acc) begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d    = S_RD_WAIT;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (RF_RD_VLD) begin
          tx_data_d  = RF_RD_DATA;
          tx_vld_d   = 1'b1;
          seen_low_d = ~TX_BUSY;
          state_d    = S_TX_REQ;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      S_TX_REQ: begin
        // A busy level already present at entry is not a handshake; it must
        // drop and rise again before the request is considered taken.
        if (TX_BUSY && seen_low_q) begin
          tx_vld_d = 1'b0;
          state_d  = S_IDLE;
        end else if (!TX_BUSY) begin
          seen_low_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      cmd_err_d = 1'b1;
`ifdef UART_CMD_ERR_RESP_EN
      tx_data_d  = ERR_BYTE;
      tx_vld_d   = 1'b1;
      seen_low_d = ~TX_BUSY;
      state_d    = S_TX_REQ;
`else
      state_d = S_IDLE;
`endif
    end
  end

  // State and output registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rx_vld_q     <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      seen_low_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_vld_q     <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_data_q <= '0;
      rf_rd_en_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_vld_q     <= rx_vld_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      seen_low_q   <= seen_low_d;
      tx_data_q    <= tx_data_d;
      tx_vld_q     <= tx_vld_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_rd_en_q   <= rf_rd_en_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign TX_P_DATA  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign RF_ADDR    = rf_addr_q;
  assign RF_WR_EN   = rf_wr_en_q;
  assign RF_WR_DATA = rf_wr_data_q;
  assign RF_RD_EN   = rf_rd_en_q;
  assign CMD_ERR    = cmd_err_q;

endmodule
